rs_seq_divider: RTL and testbench

//   Iterative radix-2 restoring divider: the inverse of the carry-chain adder

---
 rtl/rs_seq_divider.sv | 167 ++++++++++++++++
 tb/tb_rs_seq_divider.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/rs_seq_divider.sv
// Radix-2 restoring sequential divider, one quotient bit per cycle.
// Define RS_SEQ_DIV_SIGNED_EN to honour signed_op (two's-complement divide).
module rs_seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] a_q, b_q, rem_q, quo_q;
  logic [CW-1:0]    cnt_q;
  logic             dz_q, ovf_q;

  logic [WIDTH-1:0] a_abs, b_abs, q_fix, r_fix;
  logic [WIDTH:0]   shifted, trial;
  logic             ovf_n;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (start) state_n = S_PREP;
      S_PREP: state_n = S_ITER;
      S_ITER: if (cnt_q == LAST) state_n = S_FIX;
      S_FIX:  state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  // Trial subtract over WIDTH+1 bits; the MSB is the borrow/sign.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, b_q};

`ifdef RS_SEQ_DIV_SIGNED_EN
  logic sop_q, q_neg_q, r_neg_q;
  logic a_neg, b_neg;

  assign a_neg = sop_q & a_q[WIDTH-1];
  assign b_neg = sop_q & b_q[WIDTH-1];

  always_comb begin
    a_abs = a_neg ? (~a_q + 1'b1) : a_q;
    b_abs = b_neg ? (~b_q + 1'b1) : b_q;
    ovf_n = sop_q && (a_q == MIN) && (b_q == '1);
    q_fix = q_neg_q ? (~quo_q + 1'b1) : quo_q;
    r_fix = r_neg_q ? (~rem_q + 1'b1) : rem_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sop_q   <= 1'b0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else if (state == S_IDLE && start) begin
      sop_q <= signed_op;
    end else if (state == S_PREP) begin
      q_neg_q <= a_neg ^ b_neg;
      r_neg_q <= a_neg;
    end
  end
`else
  logic unused_signed_op;
  assign unused_signed_op = signed_op;

  always_comb begin
    a_abs = a_q;
    b_abs = b_q;
    ovf_n = 1'b0;
    q_fix = quo_q;
    r_fix = rem_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            a_q <= dividend;
            b_q <= divisor;
          end
        end
        // a_q keeps the raw dividend for the divide-by-zero remainder.
        S_PREP: begin
          quo_q <= a_abs;
          b_q   <= b_abs;
          rem_q <= '0;
          cnt_q <= '0;
          dz_q  <= (b_q == '0);
          ovf_q <= ovf_n;
        end
        S_ITER: begin
          if (trial[WIDTH]) begin
            rem_q <= shifted[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
          end else begin
            rem_q <= trial[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
          end
          cnt_q <= cnt_q + CW'(1);
        end
        S_FIX: begin
          div_by_zero <= dz_q;
          if (dz_q) begin
            quotient  <= '1;
            remainder <= a_q;
          end else if (ovf_q) begin
            quotient  <= MIN;
            remainder <= '0;
          end else begin
            quotient  <= q_fix;
            remainder <= r_fix;
          end
        end
        S_DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs_seq_divider.sv
// Bench for rs_seq_divider at WIDTH=8: vector table, scoreboard, corner sequences.
// Signed vectors are selected when RS_SEQ_DIV_SIGNED_EN is defined.
module tb_rs_seq_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         signed_op;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  rs_seq_divider #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .signed_op(signed_op),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Cycle 0 is the start cycle; sampling at the negedge of cycle k.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [W-1:0] eq,
                        input logic [W-1:0] er, input logic edz,
                        input int p1, input int p2, input int rst_at);
    exp_t e;
    exp_t got;
    int   done_cyc;
    int   ndone;
    bit   busy_ok;
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    signed_op = s;
    start     = 1'b1;
    if (rst_at < 0) begin
      e = '{q: eq, r: er, dz: edz};
      sb.push_back(e);
    end
    done_cyc = -1;
    ndone    = 0;
    busy_ok  = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rst_at >= 0 && k == rst_at + 1) begin
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_remainder", 32'(remainder), 32'd0);
        chk("rst_dz", 32'(div_by_zero), 32'd0);
      end
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = k;
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          got = sb.pop_front();
          chk("quotient", 32'(quotient), 32'(got.q));
          chk("remainder", 32'(remainder), 32'(got.r));
          chk("div_by_zero", 32'(div_by_zero), 32'(got.dz));
        end
      end
      if (rst_at < 0 && k <= W + 3 && !busy) busy_ok = 1'b0;
      if (rst_at < 0 && k == W + 4) chk("busy_after_done", 32'(busy), 32'd0);
      start     = (k == p1 || k == p2);
      dividend  = W'($urandom);
      divisor   = W'($urandom);
      signed_op = 1'($urandom);
      rst       = (k == rst_at);
    end
    start = 1'b0;
    rst   = 1'b0;
    if (rst_at < 0) begin
      chk("done_cycle", 32'(done_cyc), 32'(W + 3));
      chk("done_count", 32'(ndone), 32'd1);
      chk("busy_span", 32'(busy_ok), 32'd1);
      chk("quotient_held", 32'(quotient), 32'(eq));
    end else begin
      chk("aborted_done_count", 32'(ndone), 32'd0);
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb, mq, mr;
    rst       = 1'b1;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = '0;
    divisor   = '0;

    vecs.push_back('{a: 8'd100, b: 8'd7,   s: 1'b0, q: 8'd14,  r: 8'd2,  dz: 1'b0});
    vecs.push_back('{a: 8'd55,  b: 8'd0,   s: 1'b0, q: 8'hFF,  r: 8'd55, dz: 1'b1});
    vecs.push_back('{a: 8'd255, b: 8'd1,   s: 1'b0, q: 8'd255, r: 8'd0,  dz: 1'b0});
    vecs.push_back('{a: 8'd3,   b: 8'd200, s: 1'b0, q: 8'd0,   r: 8'd3,  dz: 1'b0});
    vecs.push_back('{a: 8'd255, b: 8'd255, s: 1'b0, q: 8'd1,   r: 8'd0,  dz: 1'b0});
    vecs.push_back('{a: 8'd0,   b: 8'd5,   s: 1'b0, q: 8'd0,   r: 8'd0,  dz: 1'b0});
`ifdef RS_SEQ_DIV_SIGNED_EN
    vecs.push_back('{a: 8'h9C, b: 8'h07, s: 1'b1, q: 8'hF2, r: 8'hFE, dz: 1'b0});
    vecs.push_back('{a: 8'h07, b: 8'hFE, s: 1'b1, q: 8'hFD, r: 8'h01, dz: 1'b0});
    vecs.push_back('{a: 8'h80, b: 8'hFF, s: 1'b1, q: 8'h80, r: 8'h00, dz: 1'b0});
    vecs.push_back('{a: 8'hFB, b: 8'h00, s: 1'b1, q: 8'hFF, r: 8'hFB, dz: 1'b1});
    vecs.push_back('{a: 8'h9C, b: 8'hF9, s: 1'b1, q: 8'h0E, r: 8'hFE, dz: 1'b0});
`else
    vecs.push_back('{a: 8'hF2, b: 8'h07, s: 1'b1, q: 8'd34, r: 8'd4,   dz: 1'b0});
    vecs.push_back('{a: 8'h80, b: 8'hFF, s: 1'b1, q: 8'd0,  r: 8'h80,  dz: 1'b0});
`endif

    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_quotient", 32'(quotient), 32'd0);
    chk("reset_remainder", 32'(remainder), 32'd0);
    chk("reset_dz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;

    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].q, vecs[i].r,
             vecs[i].dz, -1, -1, -1);

    // Starts while busy and in the done cycle must be ignored.
    run_op(8'd100, 8'd7, 1'b0, 8'd14, 8'd2, 1'b0, 3, 11, -1);
    // Reset in cycle 5 aborts the operation.
    run_op(8'd55, 8'd3, 1'b0, 8'd0, 8'd0, 1'b0, -1, -1, 5);
    run_op(8'd200, 8'd9, 1'b0, 8'd22, 8'd2, 1'b0, -1, -1, -1);

    for (int n = 0; n < 8; n++) begin
      ra = W'($urandom);
      rb = (n == 3) ? '0 : W'($urandom_range(1, 255));
      if (rb == '0) begin
        mq = '1;
        mr = ra;
      end else begin
        mq = ra / rb;
        mr = ra % rb;
      end
      run_op(ra, rb, 1'b0, mq, mr, (rb == '0), -1, -1, -1);
    end

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
